// File: rtl/count_down.sv
// count_down: presettable modulo down-counter with wrap/borrow or one-shot done
module count_down #(
    parameter int N       = 4,
    parameter int MOD     = 9,
    parameter bit ONESHOT = 1'b0
) (
    input  logic         clk,
    input  logic         clr,
    input  logic         en,
    input  logic         load,
    input  logic [N-1:0] d,
    output logic [N-1:0] Q,
    output logic         borrow,
    output logic         zero,
    output logic         done
);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    localparam logic [N-1:0] MOD_V = MOD[N-1:0];
    state_t       state_q, state_d;
    logic [N-1:0] q_q, q_d;
    logic         borrow_q, borrow_d;
    logic         done_q, done_d;
    logic [N-1:0] load_val;
    assign load_val = (d > MOD_V) ? MOD_V : d;
    // next-state and next-output logic: load beats en, borrow is a single-cycle pulse
    always_comb begin
        state_d  = state_q;
        q_d      = q_q;
        borrow_d = 1'b0;
        if (load) begin
            state_d = RUN;
            q_d     = load_val;
        end else begin
            case (state_q)
                IDLE: state_d = en ? RUN : IDLE;
                RUN: begin
                    if (en) begin
                        if (q_q != '0) begin
                            q_d = q_q - N'(1);
                        end else if (ONESHOT) begin
                            state_d = DONE;
                        end else begin
                            q_d      = MOD_V;
                            borrow_d = 1'b1;
                        end
                    end
                end
                DONE: q_d = '0;
                default: state_d = IDLE;
            endcase
        end
        done_d = ONESHOT && (state_d == DONE);
    end
    // state and registered outputs, cleared asynchronously by clr
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state_q  <= IDLE;
            q_q      <= '0;
            borrow_q <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            q_q      <= q_d;
            borrow_q <= borrow_d;
            done_q   <= done_d;
        end
    end
    assign Q      = q_q;
    assign borrow = borrow_q;
    assign done   = done_q;
    assign zero   = (q_q == '0);
endmodule

// File: tb/tb_count_down.sv
// tb_count_down: directed and randomized checks of count_down against a behavioural model
module tb_count_down;
    logic clk = 1'b0;
    logic clr = 1'b1;
    always #5 clk = ~clk;
    int errors = 0;
    int checks = 0;
    logic       a_en = 0, a_load = 0;
    logic [3:0] a_d = 0, a_q;
    logic       a_b, a_z, a_dn;
    logic       b_en = 0, b_load = 0;
    logic [3:0] b_d = 0, b_q;
    logic       b_b, b_z, b_dn;
    logic       u_en = 0, u_load = 0, t_load = 0;
    logic [3:0] u_d = 0, t_d = 0, u_q, t_q;
    logic       u_b, u_z, u_dn, t_b, t_z, t_dn;
    count_down #(.N(4), .MOD(9), .ONESHOT(1'b0)) dut_a (
        .clk(clk), .clr(clr), .en(a_en), .load(a_load), .d(a_d),
        .Q(a_q), .borrow(a_b), .zero(a_z), .done(a_dn));
    count_down #(.N(4), .MOD(9), .ONESHOT(1'b1)) dut_b (
        .clk(clk), .clr(clr), .en(b_en), .load(b_load), .d(b_d),
        .Q(b_q), .borrow(b_b), .zero(b_z), .done(b_dn));
    count_down #(.N(4), .MOD(9), .ONESHOT(1'b0)) units (
        .clk(clk), .clr(clr), .en(u_en), .load(u_load), .d(u_d),
        .Q(u_q), .borrow(u_b), .zero(u_z), .done(u_dn));
    count_down #(.N(4), .MOD(9), .ONESHOT(1'b0)) tens (
        .clk(clk), .clr(clr), .en(u_b), .load(t_load), .d(t_d),
        .Q(t_q), .borrow(t_b), .zero(t_z), .done(t_dn));
    // reference: count value, whether counting has started, whether the one-shot finished, last wrap
    int m_q[2];
    bit m_run[2], m_fin[2], m_b[2];
    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_q[k] = 0; m_run[k] = 0; m_fin[k] = 0; m_b[k] = 0;
        end
    endtask
    task automatic model_step(input int k, input bit os, input bit ld, input bit e, input int dv);
        m_b[k] = 0;
        if (ld) begin
            m_q[k] = (dv > 9) ? 9 : dv; m_run[k] = 1; m_fin[k] = 0;
        end else if (!m_run[k]) begin
            if (e) m_run[k] = 1;
        end else if (!m_fin[k] && e) begin
            if (m_q[k] > 0) m_q[k] = m_q[k] - 1;
            else if (os) m_fin[k] = 1;
            else begin m_q[k] = 9; m_b[k] = 1; end
        end
    endtask
    task automatic cycle();
        bit la = a_load, ea = a_en, lb = b_load, eb = b_en;
        int da = a_d, db = b_d;
        @(posedge clk);
        #1;
        if (clr) model_reset();
        else begin
            model_step(0, 1'b0, la, ea, da);
            model_step(1, 1'b1, lb, eb, db);
        end
    endtask
    task automatic test_reset();
        a_load = 1; a_d = 5; cycle(); a_load = 0;
        checks++; if (a_q !== 4'd5) begin errors++; $display("FAIL reset_preload q=%0d exp=5", a_q); end
        #3 clr = 1; #1;
        checks++; if (a_q !== 4'd0) begin errors++; $display("FAIL reset_async_q q=%0d exp=0", a_q); end
        checks++; if (a_z !== 1'b1) begin errors++; $display("FAIL reset_async_zero zero=%0b exp=1", a_z); end
        checks++; if (a_b !== 1'b0 || b_dn !== 1'b0) begin errors++; $display("FAIL reset_async_flags borrow=%0b done=%0b exp=0", a_b, b_dn); end
        model_reset();
        cycle(); clr = 0;
        for (int i = 0; i < 3; i++) begin
            cycle();
            checks++; if (a_q !== 4'd0) begin errors++; $display("FAIL reset_hold cyc=%0d q=%0d exp=0", i, a_q); end
        end
    endtask
    task automatic test_wrap();
        int exp_q[6] = '{3, 2, 1, 0, 9, 8};
        a_load = 1; a_d = 3; a_en = 0; cycle(); a_load = 0; a_en = 1;
        checks++; if (a_q !== 4'd3 || a_b !== 1'b0) begin errors++; $display("FAIL wrap_load q=%0d b=%0b exp=3/0", a_q, a_b); end
        for (int i = 1; i < 6; i++) begin
            cycle();
            checks++; if (a_q !== 4'(exp_q[i])) begin errors++; $display("FAIL wrap_q step=%0d q=%0d exp=%0d", i, a_q, exp_q[i]); end
            checks++; if (a_b !== (exp_q[i] == 9)) begin errors++; $display("FAIL wrap_borrow step=%0d b=%0b exp=%0b", i, a_b, exp_q[i] == 9); end
            checks++; if (a_z !== (exp_q[i] == 0)) begin errors++; $display("FAIL wrap_zero step=%0d z=%0b exp=%0b", i, a_z, exp_q[i] == 0); end
        end
        a_en = 0;
    endtask
    task automatic test_load_priority();
        a_load = 1; a_en = 1; a_d = 12; cycle(); a_load = 0;
        checks++; if (a_q !== 4'd9 || a_b !== 1'b0) begin errors++; $display("FAIL load_saturate q=%0d b=%0b exp=9/0", a_q, a_b); end
        cycle(); cycle();
        checks++; if (a_q !== 4'd7) begin errors++; $display("FAIL load_count q=%0d exp=7", a_q); end
        a_load = 1; a_d = 4; cycle(); a_load = 0; a_en = 0;
        checks++; if (a_q !== 4'd4) begin errors++; $display("FAIL load_over_en q=%0d exp=4", a_q); end
    endtask
    task automatic test_oneshot();
        int exp_q[5]  = '{1, 0, 0, 0, 0};
        bit exp_dn[5] = '{0, 0, 1, 1, 1};
        b_load = 1; b_d = 2; b_en = 1; cycle(); b_load = 0;
        checks++; if (b_q !== 4'd2 || b_dn !== 1'b0) begin errors++; $display("FAIL oneshot_load q=%0d done=%0b exp=2/0", b_q, b_dn); end
        for (int i = 0; i < 5; i++) begin
            cycle();
            checks++; if (b_q !== 4'(exp_q[i]) || b_dn !== exp_dn[i]) begin errors++; $display("FAIL oneshot_seq step=%0d q=%0d done=%0b exp=%0d/%0b", i, b_q, b_dn, exp_q[i], exp_dn[i]); end
            checks++; if (b_b !== 1'b0) begin errors++; $display("FAIL oneshot_borrow step=%0d b=%0b exp=0", i, b_b); end
        end
        b_load = 1; b_d = 5; cycle(); b_load = 0; b_en = 0;
        checks++; if (b_q !== 4'd5 || b_dn !== 1'b0) begin errors++; $display("FAIL oneshot_reload q=%0d done=%0b exp=5/0", b_q, b_dn); end
    endtask
    task automatic test_cascade();
        u_load = 1; u_d = 0; t_load = 1; t_d = 1; cycle(); u_load = 0; t_load = 0;
        checks++; if (u_q !== 4'd0 || t_q !== 4'd1) begin errors++; $display("FAIL cascade_load u=%0d t=%0d exp=0/1", u_q, t_q); end
        u_en = 1; cycle();
        checks++; if (u_q !== 4'd9 || u_b !== 1'b1) begin errors++; $display("FAIL cascade_wrap u=%0d b=%0b exp=9/1", u_q, u_b); end
        cycle();
        checks++; if (u_q !== 4'd8 || t_q !== 4'd0) begin errors++; $display("FAIL cascade_tens u=%0d t=%0d exp=8/0", u_q, t_q); end
        repeat (3) cycle();
        checks++; if (u_q !== 4'd5 || t_q !== 4'd0 || !t_z) begin errors++; $display("FAIL cascade_later u=%0d t=%0d exp=5/0", u_q, t_q); end
        checks++; if (t_b !== 1'b0 || u_dn !== 1'b0 || t_dn !== 1'b0) begin errors++; $display("FAIL cascade_flags tb=%0b ud=%0b td=%0b exp=0", t_b, u_dn, t_dn); end
        u_en = 0;
    endtask
    task automatic test_start_latency();
        #2 clr = 1; #2 clr = 0; model_reset();
        a_en = 1; cycle();
        checks++; if (a_q !== 4'd0 || a_b !== 1'b0 || a_z !== 1'b1) begin errors++; $display("FAIL start_first q=%0d b=%0b z=%0b exp=0/0/1", a_q, a_b, a_z); end
        cycle();
        checks++; if (a_q !== 4'd9 || a_b !== 1'b1) begin errors++; $display("FAIL start_wrap q=%0d b=%0b exp=9/1", a_q, a_b); end
        a_en = 0;
        for (int i = 0; i < 2; i++) begin
            cycle();
            checks++; if (a_q !== 4'd9 || a_b !== 1'b0) begin errors++; $display("FAIL start_pause cyc=%0d q=%0d b=%0b exp=9/0", i, a_q, a_b); end
        end
    endtask
    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            a_load = ($urandom_range(0, 7) == 0); a_en = ($urandom_range(0, 3) != 0); a_d = 4'($urandom_range(0, 15));
            b_load = ($urandom_range(0, 9) == 0); b_en = ($urandom_range(0, 3) != 0); b_d = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 60) == 0) begin
                #2 clr = 1; #2 clr = 0; model_reset();
            end
            cycle();
            checks++; if (a_q !== 4'(m_q[0]) || a_b !== m_b[0] || a_dn !== 1'b0 || a_z !== (m_q[0] == 0)) begin
                errors++; $display("FAIL rand_a cyc=%0d q=%0d b=%0b dn=%0b z=%0b exp=%0d/%0b/0", i, a_q, a_b, a_dn, a_z, m_q[0], m_b[0]);
            end
            checks++; if (b_q !== 4'(m_q[1]) || b_b !== m_b[1] || b_dn !== m_fin[1] || b_z !== (m_q[1] == 0)) begin
                errors++; $display("FAIL rand_b cyc=%0d q=%0d b=%0b dn=%0b z=%0b exp=%0d/%0b/%0b", i, b_q, b_b, b_dn, b_z, m_q[1], m_b[1], m_fin[1]);
            end
        end
        a_load = 0; a_en = 0; b_load = 0; b_en = 0;
    endtask
    initial begin
        model_reset();
        repeat (2) @(posedge clk);
        #1 clr = 0;
        test_reset();
        test_wrap();
        test_load_priority();
        test_oneshot();
        test_cascade();
        test_start_latency();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
